// File: rtl/timer_ctrl_pkg.sv
// Shared types for timer_ctrl: opcode and FSM state encodings, default widths.
// Optional TIMER_CTRL_IRQ_CNT_EN makes opcode 7 (READ_IRQ_CNT) legal.
package timer_ctrl_pkg;

  localparam int COUNT_W_DEF = 32;
  localparam int IRQ_CNT_W   = 8;

  typedef enum logic [2:0] {
    OP_START        = 3'd0,
    OP_CAPTURE      = 3'd1,
    OP_CLR_CAP      = 3'd2,
    OP_SET_ALARM    = 3'd3,
    OP_DIS_ALARM    = 3'd4,
    OP_RST_TMR      = 3'd5,
    OP_READ         = 3'd6,
    OP_READ_IRQ_CNT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_CAP = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  function automatic logic op_legal(op_e op);
`ifdef TIMER_CTRL_IRQ_CNT_EN
    return (op == op) ? 1'b1 : 1'b0;
`else
    return (op != OP_READ_IRQ_CNT);
`endif
  endfunction

endpackage

// File: rtl/timer_ctrl_irq.sv
// Alarm edge detector feeding a sticky, acknowledgeable interrupt.
// With TIMER_CTRL_IRQ_CNT_EN, also an 8-bit saturating count of alarm edges.
module timer_ctrl_irq
  import timer_ctrl_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_an_in,
  input  logic                 alarm_in,
  input  logic                 ack_in,
  input  logic                 clr_in,
`ifdef TIMER_CTRL_IRQ_CNT_EN
  input  logic                 cnt_clr_in,
  output logic [IRQ_CNT_W-1:0] cnt_out,
`endif
  output logic                 irq_out
);

  logic alarm_q;
  logic alarm_rise;

  assign alarm_rise = alarm_in & ~alarm_q;

  // A new edge always wins over ack or a timer-reset clear in the same cycle.
  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      alarm_q <= 1'b0;
      irq_out <= 1'b0;
    end else begin
      alarm_q <= alarm_in;
      if (alarm_rise)
        irq_out <= 1'b1;
      else if (ack_in || clr_in)
        irq_out <= 1'b0;
    end
  end

`ifdef TIMER_CTRL_IRQ_CNT_EN
  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in)
      cnt_out <= '0;
    else if (cnt_clr_in)
      cnt_out <= alarm_rise ? IRQ_CNT_W'(1) : '0;
    else if (alarm_rise && (cnt_out != {IRQ_CNT_W{1'b1}}))
      cnt_out <= cnt_out + 1'b1;
  end
`endif

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven initiator for the timer control interface: one command in
// flight, pulse/level generation, response capture. Option: TIMER_CTRL_IRQ_CNT_EN.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int CAP_LAT = 2
) (
  input  logic               clk_in,
  input  logic               rst_an_in,
  input  logic               cmd_valid_in,
  output logic               cmd_ready_out,
  input  logic [2:0]         cmd_op_in,
  input  logic [COUNT_W-1:0] cmd_data_in,
  output logic               rsp_valid_out,
  input  logic               rsp_ready_in,
  output logic [COUNT_W-1:0] rsp_data_out,
  output logic               rsp_err_out,
  output logic               tmr_rst_out,
  output logic               tmr_start_out,
  output logic               tmr_capture_out,
  output logic               tmr_rst_capture_out,
  output logic               tmr_alarm_en_out,
  output logic [COUNT_W-1:0] tmr_alarm_out,
  input  logic [COUNT_W-1:0] tmr_captured_in,
  input  logic [COUNT_W-1:0] tmr_counter_in,
  input  logic               tmr_alarm_in,
  output logic               irq_out,
  input  logic               irq_ack_in
);

  localparam logic [3:0] WAIT_INIT = 4'(CAP_LAT - 1);

  state_e             state, state_next;
  op_e                op_q;
  op_e                op_in;
  logic [COUNT_W-1:0] data_q;
  logic [3:0]         wait_cnt;
  logic [COUNT_W-1:0] issue_data;
  logic               issue_err;

  assign op_in         = op_e'(cmd_op_in);
  assign cmd_ready_out = (state == ST_IDLE);
  assign rsp_valid_out = (state == ST_RESP);

`ifdef TIMER_CTRL_IRQ_CNT_EN
  logic [IRQ_CNT_W-1:0] irq_cnt;
`endif

  timer_ctrl_irq u_irq (
    .clk_in     (clk_in),
    .rst_an_in  (rst_an_in),
    .alarm_in   (tmr_alarm_in),
    .ack_in     (irq_ack_in),
    .clr_in     (tmr_rst_out),
`ifdef TIMER_CTRL_IRQ_CNT_EN
    .cnt_clr_in ((state == ST_ISSUE) && (op_q == OP_READ_IRQ_CNT)),
    .cnt_out    (irq_cnt),
`endif
    .irq_out    (irq_out)
  );

  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (cmd_valid_in) state_next = ST_ISSUE;
      ST_ISSUE:    state_next = (op_q == OP_CAPTURE) ? ST_WAIT_CAP : ST_RESP;
      ST_WAIT_CAP: if (wait_cnt == 4'd0) state_next = ST_RESP;
      ST_RESP:     if (rsp_ready_in) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Response value for every op except CAPTURE, sampled at the end of ISSUE.
  always_comb begin
    issue_data = '0;
    issue_err  = ~op_legal(op_q);
    case (op_q)
      OP_SET_ALARM: issue_data = data_q;
      OP_READ:      issue_data = tmr_counter_in;
`ifdef TIMER_CTRL_IRQ_CNT_EN
      OP_READ_IRQ_CNT: issue_data = COUNT_W'(irq_cnt);
`endif
      default:      issue_data = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_an_in) begin
    if (!rst_an_in) begin
      op_q                <= OP_START;
      data_q              <= '0;
      wait_cnt            <= '0;
      rsp_data_out        <= '0;
      rsp_err_out         <= 1'b0;
      tmr_rst_out         <= 1'b0;
      tmr_start_out       <= 1'b0;
      tmr_capture_out     <= 1'b0;
      tmr_rst_capture_out <= 1'b0;
      tmr_alarm_en_out    <= 1'b0;
      tmr_alarm_out       <= '0;
    end else begin
      tmr_rst_out         <= 1'b0;
      tmr_start_out       <= 1'b0;
      tmr_capture_out     <= 1'b0;
      tmr_rst_capture_out <= 1'b0;
      case (state)
        // Pulses and alarm levels are registered at accept so they land in ISSUE.
        ST_IDLE: if (cmd_valid_in) begin
          op_q   <= op_in;
          data_q <= cmd_data_in;
          case (op_in)
            OP_START:     tmr_start_out       <= 1'b1;
            OP_CAPTURE:   tmr_capture_out     <= 1'b1;
            OP_CLR_CAP:   tmr_rst_capture_out <= 1'b1;
            OP_SET_ALARM: begin
              tmr_alarm_out    <= cmd_data_in;
              tmr_alarm_en_out <= 1'b1;
            end
            OP_DIS_ALARM: tmr_alarm_en_out <= 1'b0;
            OP_RST_TMR: begin
              tmr_rst_out      <= 1'b1;
              tmr_alarm_en_out <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_ISSUE: begin
          wait_cnt <= WAIT_INIT;
          if (op_q != OP_CAPTURE) begin
            rsp_data_out <= issue_data;
            rsp_err_out  <= issue_err;
          end
        end
        ST_WAIT_CAP: begin
          if (wait_cnt == 4'd0) begin
            rsp_data_out <= tmr_captured_in;
            rsp_err_out  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (CAP_LAT=2); op 7 expectations follow
// TIMER_CTRL_IRQ_CNT_EN.
module tb_timer_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_an;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [W-1:0] rsp_data;
  logic         tmr_rst, tmr_start, tmr_capture, tmr_rst_capture, tmr_alarm_en;
  logic [W-1:0] tmr_alarm, tmr_captured, tmr_counter;
  logic         alarm_in, irq, irq_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.COUNT_W(W), .CAP_LAT(2)) dut (
    .clk_in              (clk),
    .rst_an_in           (rst_an),
    .cmd_valid_in        (cmd_valid),
    .cmd_ready_out       (cmd_ready),
    .cmd_op_in           (cmd_op),
    .cmd_data_in         (cmd_data),
    .rsp_valid_out       (rsp_valid),
    .rsp_ready_in        (rsp_ready),
    .rsp_data_out        (rsp_data),
    .rsp_err_out         (rsp_err),
    .tmr_rst_out         (tmr_rst),
    .tmr_start_out       (tmr_start),
    .tmr_capture_out     (tmr_capture),
    .tmr_rst_capture_out (tmr_rst_capture),
    .tmr_alarm_en_out    (tmr_alarm_en),
    .tmr_alarm_out       (tmr_alarm),
    .tmr_captured_in     (tmr_captured),
    .tmr_counter_in      (tmr_counter),
    .tmr_alarm_in        (alarm_in),
    .irq_out             (irq),
    .irq_ack_in          (irq_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command while IDLE; returns in cycle T+1 with inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd5;
    cmd_data  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    rst_an = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    rsp_ready = 1'b1; tmr_captured = '0; tmr_counter = '0;
    alarm_in = 1'b0; irq_ack = 1'b0;
    #22;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if ({rsp_valid, rsp_err, irq} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rsp_valid, rsp_err, irq}); end
    checks++; if ({tmr_rst, tmr_start, tmr_capture, tmr_rst_capture, tmr_alarm_en} !== 5'b0) begin errors++; $display("FAIL reset_tmr: got %b expected 00000", {tmr_rst, tmr_start, tmr_capture, tmr_rst_capture, tmr_alarm_en}); end
    checks++; if ({tmr_alarm, rsp_data} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {tmr_alarm, rsp_data}); end
    rst_an = 1'b1;
    tick();
  endtask

  task automatic test_start();
    issue(3'd0, 32'h1111_2222);
    checks++; if ({tmr_start, cmd_ready, rsp_valid} !== 3'b100) begin errors++; $display("FAIL start_t1: got %b expected 100", {tmr_start, cmd_ready, rsp_valid}); end
    tick();
    checks++; if ({tmr_start, rsp_valid, rsp_err} !== 3'b010) begin errors++; $display("FAIL start_t2: got %b expected 010", {tmr_start, rsp_valid, rsp_err}); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL start_data: got %h expected 0", rsp_data); end
    tick();
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL start_t3: got %b expected 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_capture();
    tmr_captured = 32'hDEAD_0000;
    issue(3'd1, '0);
    checks++; if ({tmr_capture, tmr_start} !== 2'b10) begin errors++; $display("FAIL cap_t1: got %b expected 10", {tmr_capture, tmr_start}); end
    tick();
    checks++; if ({tmr_capture, rsp_valid} !== 2'b00) begin errors++; $display("FAIL cap_t2: got %b expected 00", {tmr_capture, rsp_valid}); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cap_t3: got %b expected 0", rsp_valid); end
    tmr_captured = 32'h0000_1234;
    tick();
    tmr_captured = 32'h0000_0BAD;
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) begin errors++; $display("FAIL cap_t4: got %b expected 10", {rsp_valid, rsp_err}); end
    checks++; if (rsp_data !== 32'h0000_1234) begin errors++; $display("FAIL cap_data: got %h expected 00001234", rsp_data); end
    tick();
  endtask

  task automatic test_alarm();
    issue(3'd3, 32'h64);
    checks++; if ({tmr_alarm_en, tmr_alarm} !== {1'b1, 32'h64}) begin errors++; $display("FAIL alarm_set: got %b %h expected 1 00000064", tmr_alarm_en, tmr_alarm); end
    tick();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h64}) begin errors++; $display("FAIL alarm_rsp: got %b %h expected 1 00000064", rsp_valid, rsp_data); end
    tick();
    alarm_in = 1'b1;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
    alarm_in = 1'b0;
    tick();
    alarm_in = 1'b1; irq_ack = 1'b1;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    tick();
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack: got %b expected 0", irq); end
    issue(3'd4, 32'h99);
    checks++; if ({tmr_alarm_en, tmr_alarm} !== {1'b0, 32'h64}) begin errors++; $display("FAIL alarm_dis: got %b %h expected 0 00000064", tmr_alarm_en, tmr_alarm); end
    tick(); tick();
  endtask

  task automatic test_rst_tmr();
    issue(3'd3, 32'h200); tick(); tick();
    alarm_in = 1'b0; tick();
    alarm_in = 1'b1; tick();
    issue(3'd5, '0);
    checks++; if ({tmr_rst, tmr_alarm_en, irq} !== 3'b101) begin errors++; $display("FAIL rst_tmr_t1: got %b expected 101", {tmr_rst, tmr_alarm_en, irq}); end
    tick();
    checks++; if ({tmr_rst, irq, rsp_valid} !== 3'b001) begin errors++; $display("FAIL rst_tmr_t2: got %b expected 001", {tmr_rst, irq, rsp_valid}); end
    checks++; if ({rsp_err, rsp_data} !== 33'h0) begin errors++; $display("FAIL rst_tmr_data: got %b %h expected 0 0", rsp_err, rsp_data); end
    tick();
  endtask

  task automatic test_op7();
    alarm_in = 1'b0;
    tick();
`ifdef TIMER_CTRL_IRQ_CNT_EN
    issue(3'd7, '0); tick(); tick();
    for (int i = 0; i < 300; i++) begin
      alarm_in = 1'b1; tick();
      alarm_in = 1'b0; tick();
    end
    issue(3'd7, '0); tick();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'd255}) begin errors++; $display("FAIL irq_cnt_sat: got %b %b %h expected 1 0 000000ff", rsp_valid, rsp_err, rsp_data); end
    tick();
    issue(3'd7, '0); tick();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'd0}) begin errors++; $display("FAIL irq_cnt_clr: got %b %b %h expected 1 0 0", rsp_valid, rsp_err, rsp_data); end
    tick();
`else
    issue(3'd7, 32'h55);
    checks++; if ({tmr_rst, tmr_start, tmr_capture, tmr_rst_capture} !== 4'b0) begin errors++; $display("FAIL op7_pulses: got %b expected 0000", {tmr_rst, tmr_start, tmr_capture, tmr_rst_capture}); end
    checks++; if (tmr_alarm !== 32'h200) begin errors++; $display("FAIL op7_alarm: got %h expected 00000200", tmr_alarm); end
    tick();
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'd0}) begin errors++; $display("FAIL op7_illegal: got %b %b %h expected 1 1 0", rsp_valid, rsp_err, rsp_data); end
    tick();
`endif
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    tmr_counter = 32'h55;
    issue(3'd6, '0);
    tmr_counter = 32'h77;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rsp_valid, cmd_ready, rsp_err, rsp_data} !== {3'b100, 32'h77}) begin errors++; $display("FAIL bp_hold%0d: got %b%b%b %h expected 100 00000077", i, rsp_valid, cmd_ready, rsp_err, rsp_data); end
      tmr_counter = tmr_counter + 32'h1;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %b expected 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    cmd_valid = 1'b1; cmd_op = 3'd0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (tmr_start === 1'b1) pulses++;
    end
    cmd_valid = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_rate: got %0d expected 3", pulses); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_async_reset();
    issue(3'd3, 32'h300); tick(); tick();
    alarm_in = 1'b1; tick();
    alarm_in = 1'b0;
    issue(3'd1, '0);
    tick();
    #2 rst_an = 1'b0;
    #1;
    checks++; if ({cmd_ready, tmr_alarm_en, irq, tmr_capture} !== 4'b1000) begin errors++; $display("FAIL arst_state: got %b expected 1000", {cmd_ready, tmr_alarm_en, irq, tmr_capture}); end
    rst_an = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL arst_norsp%0d: got %b expected 01", i, {rsp_valid, cmd_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_capture();
    test_alarm();
    test_rst_tmr();
    test_op7();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
